eq_gain_ctrl: RTL and testbench

EQ_GAIN_CTRL -- requirements
Module: eq_gain_ctrl

---
 rtl/eq_gain_ctrl.sv | 153 +++++++++++++++
 tb/tb_eq_gain_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/eq_gain_ctrl.sv
// eq_gain_ctrl: key-driven per-channel EQ gain editor with a
// valid/ready coefficient update stream to the DSP.
module eq_gain_ctrl #(
  parameter int N_BAND   = 6,
  parameter int N_CH     = 2,
  parameter int GAIN_W   = 6,
  parameter int GAIN_MAX = 12,
  parameter int GAIN_MIN = -12,
  localparam int BW = $clog2(N_BAND),
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_init_done,
  input  logic                     i_select,
  input  logic                     i_back,
  input  logic                     i_up,
  input  logic                     i_down,
  input  logic                     i_clear,
  input  logic                     i_link,
  input  logic [CW-1:0]            i_ch,
  output logic [2:0]               o_state,
  output logic [BW-1:0]            o_band,
  output logic signed [GAIN_W-1:0] o_gain,
  output logic                     o_upd_valid,
  input  logic                     i_upd_ready,
  output logic [CW-1:0]            o_upd_ch,
  output logic [BW-1:0]            o_upd_band,
  output logic signed [GAIN_W-1:0] o_upd_gain,
  output logic                     o_busy
);
  typedef enum logic [2:0] {INIT = 3'd0, FLUSH = 3'd1, IDLE = 3'd2, BAND_SEL = 3'd3, SET_GAIN = 3'd4} state_t;
  localparam logic signed [GAIN_W-1:0] GMAX = GAIN_W'(GAIN_MAX);
  localparam logic signed [GAIN_W-1:0] GMIN = GAIN_W'(GAIN_MIN);
  localparam logic signed [GAIN_W-1:0] ONE  = GAIN_W'(1);
  localparam logic [CW-1:0] CH_LAST = CW'(N_CH - 1);
  localparam logic [BW-1:0] BAND_LAST = BW'(N_BAND - 1);
  state_t state_q, state_d;
  logic [BW-1:0] band_q, band_d, upd_band_q, upd_band_d;
  logic [CW-1:0] upd_ch_q, upd_ch_d, ch_s;
  logic valid_q, valid_d;
  logic [N_CH-1:0] pend_q, pend_d, chg;
  logic signed [GAIN_W-1:0] gain_q [N_CH][N_BAND];
  logic signed [GAIN_W-1:0] gain_d [N_CH][N_BAND];
  logic signed [GAIN_W-1:0] cur, nxt;
  logic busy, hs, k_sel, k_up, k_dn, k_clr;

  function automatic logic [CW-1:0] first_set(input logic [N_CH-1:0] m);
    first_set = '0;
    for (int c = N_CH - 1; c >= 0; c--) if (m[c]) first_set = CW'(c);
  endfunction

  assign busy  = (state_q == INIT) || (state_q == FLUSH) || valid_q;
  assign hs    = valid_q && i_upd_ready;
  // back is never masked; the others only act when idle and not outranked
  assign k_sel = i_select && !i_back && !busy;
  assign k_up  = i_up && !i_select && !i_back && !busy;
  assign k_dn  = i_down && !i_up && !i_select && !i_back && !busy;
  assign k_clr = i_clear && !i_down && !i_up && !i_select && !i_back && !busy;
  assign ch_s  = (int'(i_ch) >= N_CH) ? CH_LAST : i_ch;
  assign cur   = gain_q[ch_s][band_q];
  assign nxt   = k_up ? ((cur >= GMAX) ? GMAX : cur + ONE) : ((cur <= GMIN) ? GMIN : cur - ONE);

  always_comb begin
    state_d    = state_q;
    band_d     = band_q;
    gain_d     = gain_q;
    valid_d    = valid_q;
    upd_ch_d   = upd_ch_q;
    upd_band_d = upd_band_q;
    pend_d     = pend_q;
    chg        = '0;
    if (hs && state_q != FLUSH) begin
      valid_d  = |pend_q;
      upd_ch_d = first_set(pend_q);
      pend_d   = pend_q & ~(N_CH'(1) << first_set(pend_q));
    end
    case (state_q)
      INIT: if (i_init_done) begin
        state_d    = FLUSH;
        valid_d    = 1'b1;
        upd_ch_d   = '0;
        upd_band_d = '0;
      end
      FLUSH: if (hs) begin
        if (upd_ch_q == CH_LAST && upd_band_q == BAND_LAST) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (upd_band_q == BAND_LAST) begin
          upd_band_d = '0;
          upd_ch_d   = upd_ch_q + CW'(1);
        end else upd_band_d = upd_band_q + BW'(1);
      end
      IDLE: if (k_sel) begin
        state_d = BAND_SEL;
        band_d  = '0;
      end else if (k_clr) begin
        for (int c = 0; c < N_CH; c++) for (int b = 0; b < N_BAND; b++) gain_d[c][b] = '0;
        state_d    = FLUSH;
        valid_d    = 1'b1;
        upd_ch_d   = '0;
        upd_band_d = '0;
      end
      BAND_SEL: if (i_back) state_d = IDLE;
        else if (k_sel) state_d = SET_GAIN;
        else if (k_up) band_d = (band_q == BAND_LAST) ? band_q : band_q + BW'(1);
        else if (k_dn) band_d = (band_q == '0) ? band_q : band_q - BW'(1);
      SET_GAIN: if (i_back) state_d = BAND_SEL;
        else if (k_up || k_dn) begin
          // linked edits copy the target channel's new value to every channel
          for (int c = 0; c < N_CH; c++) if (i_link || CW'(c) == ch_s) begin
            chg[c] = gain_q[c][band_q] != nxt;
            gain_d[c][band_q] = nxt;
          end
          valid_d    = |chg;
          upd_ch_d   = first_set(chg);
          upd_band_d = band_q;
          pend_d     = chg & ~(N_CH'(1) << first_set(chg));
        end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= INIT;
      band_q     <= '0;
      valid_q    <= 1'b0;
      upd_ch_q   <= '0;
      upd_band_q <= '0;
      pend_q     <= '0;
      for (int c = 0; c < N_CH; c++) for (int b = 0; b < N_BAND; b++) gain_q[c][b] <= '0;
    end else begin
      state_q    <= state_d;
      band_q     <= band_d;
      valid_q    <= valid_d;
      upd_ch_q   <= upd_ch_d;
      upd_band_q <= upd_band_d;
      pend_q     <= pend_d;
      gain_q     <= gain_d;
    end
  end

  // the table cannot change while an update is pending, so reading it keeps the payload stable
  assign o_state     = state_q;
  assign o_band      = band_q;
  assign o_gain      = cur;
  assign o_upd_valid = valid_q;
  assign o_upd_ch    = upd_ch_q;
  assign o_upd_band  = upd_band_q;
  assign o_upd_gain  = gain_q[upd_ch_q][upd_band_q];
  assign o_busy      = busy;
endmodule

// File: tb/tb_eq_gain_ctrl.sv
// tb_eq_gain_ctrl: directed vector table plus hand sequences for eq_gain_ctrl.
module tb_eq_gain_ctrl;
  localparam logic [4:0] K_SEL = 5'b10000, K_BACK = 5'b01000, K_UP = 5'b00100, K_DN = 5'b00010, K_CLR = 5'b00001;
  logic clk = 0, rst_n = 0, init_done = 0, sel = 0, back = 0, up = 0, dn = 0, clr = 0, link = 0, ready = 1;
  logic [0:0] ch = '0, uch;
  logic [2:0] st, band, uband;
  logic signed [5:0] gain, ugain;
  logic uvld, busy;
  typedef struct {int c; int b; int g;} upd_t;
  typedef struct {logic [4:0] k; int st; int band; int gain; int vld;} vec_t;
  upd_t uq[$];
  vec_t vq[$];
  int errs = 0, checks = 0;

  eq_gain_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_init_done(init_done), .i_select(sel), .i_back(back),
    .i_up(up), .i_down(dn), .i_clear(clr), .i_link(link), .i_ch(ch), .o_state(st),
    .o_band(band), .o_gain(gain), .o_upd_valid(uvld), .i_upd_ready(ready), .o_upd_ch(uch),
    .o_upd_band(uband), .o_upd_gain(ugain), .o_busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && uvld && ready) uq.push_back('{int'(uch), int'(uband), int'(ugain)});

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [4:0] k);
    {sel, back, up, dn, clr} = k;
    step();
    {sel, back, up, dn, clr} = '0;
  endtask

  task automatic wait_state(input int s, input int budget);
    int n = 0;
    while (int'(st) != s && n < budget) begin
      step();
      n++;
    end
    chk("wait_state", int'(st), s);
  endtask

  task automatic chk_upd(input string nm, input int idx, input int c, input int b, input int g);
    if (idx >= uq.size()) chk({nm, "_missing"}, uq.size(), idx + 1);
    else begin
      chk({nm, "_ch"}, uq[idx].c, c);
      chk({nm, "_band"}, uq[idx].b, b);
      chk({nm, "_gain"}, uq[idx].g, g);
    end
  endtask

  function automatic void add(input logic [4:0] k, input int s, input int b, input int g, input int v);
    vq.push_back('{k, s, b, g, v});
  endfunction

  initial begin
    int base, bad;
    logic [9:0] p;
    add(K_SEL, 3, 0, 0, 0);
    for (int i = 1; i <= 8; i++) add(K_UP, 3, (i > 5) ? 5 : i, 0, 0);
    add(K_DN, 3, 4, 0, 0);
    add(K_DN, 3, 3, 0, 0);
    add(K_SEL | K_UP, 4, 3, 0, 0);
    for (int i = 1; i <= 14; i++) add(K_UP, 4, 3, (i > 12) ? 12 : i, (i <= 12) ? 1 : 0);

    step(2);
    chk("rst_state", int'(st), 0);
    chk("rst_band", int'(band), 0);
    chk("rst_valid", int'(uvld), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_upd_gain", int'(ugain), 0);
    init_done = 1;
    rst_n = 1;
    step();
    chk("init_to_flush", int'(st), 1);
    chk("flush_first_valid", int'(uvld), 1);
    wait_state(2, 40);
    chk("flush_count", uq.size(), 12);
    for (int i = 0; i < 12; i++) chk_upd($sformatf("flush%0d", i), i, i / 6, i % 6, 0);

    link = 0;
    ch = 1'b1;
    base = uq.size();
    foreach (vq[i]) begin
      press(vq[i].k);
      chk($sformatf("vec%0d_state", i), int'(st), vq[i].st);
      chk($sformatf("vec%0d_band", i), int'(band), vq[i].band);
      chk($sformatf("vec%0d_gain", i), int'(gain), vq[i].gain);
      chk($sformatf("vec%0d_valid", i), int'(uvld), vq[i].vld);
      step(3);
    end
    chk("sat_upd_count", uq.size() - base, 12);
    chk_upd("sat_last", base + 11, 1, 3, 12);
    ch = 1'b0;
    #1;
    chk("ch0_b3_untouched", int'(gain), 0);

    press(K_BACK);
    chk("back_to_bandsel", int'(st), 3);
    repeat (3) press(K_DN);
    chk("band_down_to_0", int'(band), 0);
    press(K_SEL);
    chk("enter_setgain", int'(st), 4);
    repeat (12) begin
      press(K_DN);
      step(3);
    end
    ch = 1'b1;
    repeat (5) begin
      press(K_UP);
      step(3);
    end
    chk("ch1_b0_prep", int'(gain), 5);
    ch = 1'b0;
    #1;
    chk("ch0_b0_prep", int'(gain), -12);
    base = uq.size();
    link = 1;
    press(K_DN);
    step(3);
    chk("link_down_count", uq.size() - base, 1);
    chk_upd("link_down", base, 1, 0, -12);
    chk("link_down_ch0", int'(gain), -12);
    ch = 1'b1;
    #1;
    chk("link_down_ch1", int'(gain), -12);
    ch = 1'b0;
    base = uq.size();
    press(K_UP);
    step(3);
    chk("link_up_count", uq.size() - base, 2);
    chk_upd("link_up0", base, 0, 0, -11);
    chk_upd("link_up1", base + 1, 1, 0, -11);

    link = 0;
    ready = 0;
    press(K_UP);
    chk("stall_valid", int'(uvld), 1);
    chk("stall_payload_gain", int'(ugain), -10);
    p = {uch, uband, ugain};
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      up = (i == 3);
      step();
      up = 0;
      if (!uvld || {uch, uband, ugain} !== p) bad++;
    end
    chk("stall_stable_cycles_bad", bad, 0);
    chk("stall_up_ignored", int'(gain), -10);
    press(K_BACK);
    chk("stall_back_state", int'(st), 3);
    chk("stall_back_valid", int'(uvld), 1);
    base = uq.size();
    ready = 1;
    step();
    chk("stall_release_valid", int'(uvld), 0);
    chk("stall_release_count", uq.size() - base, 1);
    chk_upd("stall_upd", base, 0, 0, -10);

    press(K_BACK);
    chk("back_to_idle", int'(st), 2);
    chk("idle_not_busy", int'(busy), 0);
    base = uq.size();
    press(K_CLR);
    chk("clear_state", int'(st), 1);
    chk("clear_valid", int'(uvld), 1);
    wait_state(2, 40);
    chk("clear_count", uq.size() - base, 12);
    for (int i = 0; i < 12; i++) chk_upd($sformatf("clr%0d", i), base + i, i / 6, i % 6, 0);
    chk("clear_ch0_gain", int'(gain), 0);
    ch = 1'b1;
    #1;
    chk("clear_ch1_gain", int'(gain), 0);

    press(K_CLR);
    step(3);
    rst_n = 0;
    #1;
    chk("midrst_valid", int'(uvld), 0);
    chk("midrst_state", int'(st), 0);
    chk("midrst_busy", int'(busy), 1);
    init_done = 0;
    step(2);
    rst_n = 1;
    step(3);
    chk("init_hold", int'(st), 0);
    init_done = 1;
    step();
    chk("reinit_flush", int'(st), 1);
    chk("reinit_valid", int'(uvld), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end
endmodule
